cop0_intr_ctrl: RTL and testbench
=================================

# cop0_intr_ctrl

Coprocessor-0 interrupt controller that raises, latches and masks the interrupt requests serviced by the ISR ROM. It holds Count, Compare, Status, Cause and EPC, exposed to the CPU through mfc0/mtc0, and drives the CPU's interrupt-redirect request. It sits beside the MIPS datapath. Peripherals such as the UART drive its hardware request inputs.

## Interface
- `REENABLE_HOLD`, default 3: cycles that `int_req` stays suppressed after an mtc0 write that sets Status.IE.
- `clk` in 1: sole clock; everything is on the rising edge.
- `rst` in 1: synchronous reset, active-low. Registers reset when `rst==0` at a rising edge.
- `we` in 1: mtc0 write strobe, one cycle per write.
- `waddr` in 5: mtc0 destination register number.
- `wdata` in 32: mtc0 data.
- `raddr` in 5: mfc0 source register number.
- `rdata` out 32: mfc0 data (combinational).
- `hw_irq` in 5: peripheral request levels mapped to Cause bits 14:10. `hw_irq[0]` is the UART receive-ready request on Cause bit 10.
- `int_ack` in 1: the CPU is redirecting to the ISR this cycle.
- `pc_in` in 32: the resume PC, captured into EPC on an accepted `int_ack`.
- `int_req` out 1: interrupt pending and enabled.

## Operation
Register map and read values:
- 9 Count: full 32 bits, read/write.
- 11 Compare: full 32 bits, read/write.
- 12 Status: IM in bits 15:10 and IE in bit 0 are read/write; all other bits read 0.
- 13 Cause: IP in bits 15:10 is readable; all other bits read 0.
- 14 EPC: readable only.
- Any other `raddr` reads 0.

Count and Compare:
- Count increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
- An mtc0 write to Count loads `wdata` in place of the increment.
- Timer match: when the next Count value equals Compare, Cause[15] (IP7) is set.
- An mtc0 write to Compare loads Compare and clears IP7.

Hardware requests:
- Each `hw_irq[i]` is registered once. A 0→1 transition of the registered value sets Cause[10+i], which is sticky.
- An mtc0 write to Cause loads bits 14:10 from `wdata` to let software clear them.
- Cause[15] cannot be written through Cause.

Request and acknowledge:
- `int_req = IE & |(Cause[15:10] & Status[15:10]) & (hold counter == 0)`.
- An mtc0 write to Status that leaves IE=1 loads the hold counter with `REENABLE_HOLD`. The counter decrements to 0, one per cycle.
- `int_ack` while `int_req==1`: EPC <= `pc_in`, IE <= 0, IM unchanged.
- `int_ack` while `int_req==0` is ignored.

Priority rules:
- A hardware edge or timer match in the same cycle as a Cause write: the set wins.
- A timer match in the same cycle as a Compare write: the write wins (IP7 cleared). The new Compare is used from the next cycle.
- `int_ack` in the same cycle as an mtc0 Status write: IE ends at 0. IM takes `wdata`.
- mtc0 write and mfc0 read of the same register in the same cycle: `rdata` returns the old value.

## Timing
- Reset values:
  - Count, Compare, Status, Cause and EPC are 0.
  - The hold counter is 0.
  - The edge-detect registers are 0.
  - `int_req` is 0 and `rdata` is 0 for any `raddr`.
- Hardware edge latency: `hw_irq` rises at edge N, Cause bit sets at edge N+1, and `int_req` can assert in the following cycle.
- Timer latency: Count reaches Compare at edge N, IP7 is set at edge N, and `int_req` can be high in cycle N.
- Status write latency: a write at edge N with IE=1 and `REENABLE_HOLD=3` keeps `int_req` low in cycles N, N+1 and N+2. It can assert from cycle N+3. This covers the `jr $k0` and its delay slot.
- Reset mid-operation: reset overrides all pending sets, writes and acks in that cycle.

## Test plan
- **Reset.** Hold `rst=0`, then release. Required: all five registers read 0, `int_req=0`, and Count reads 1, 2, 3… on consecutive cycles.
- **Timer.**
  - Stimulus: write Status=0x00008001 and Compare=100.
  - Required: IP7 and `int_req` rise when Count reaches 100.
  - Then `int_ack` with `pc_in`=0x40.
  - Required: EPC=0x40, Status=0x00008000, `int_req=0`.
  - Then write Compare=100+50,000,000.
  - Required: Cause[15]=0.
- **UART request.**
  - Stimulus: Status=0x00000401, then pulse `hw_irq[0]` high for 5 cycles.
  - Required: Cause=0x00000400 latched exactly once, and it stays set after `hw_irq` drops.
  - Then write Cause=0x00000000.
  - Required: bit clears and `int_req=0`.
- **Masking.** With IM=0 and a pending Cause=0x4000, `int_req` must stay 0. Writing Status=0x4001 must assert `int_req` exactly `REENABLE_HOLD` cycles later.
- **Collisions.**
  - A Cause write of 0 in the same cycle as a `hw_irq[4]` edge: bit 14 must end up set.
  - A Compare write in the same cycle as a timer match: IP7 must end up 0.
- **Spurious ack and wrap.**
  - `int_ack` with `int_req=0`: EPC and IE unchanged.
  - Count=0xFFFFFFFF with Compare=0: wraps to 0 and IP7 sets.

Source files
------------

// File: rtl/cop0_intr_ctrl.sv
// Coprocessor-0 interrupt controller: Count/Compare timer, Status, Cause, EPC
// and the interrupt-redirect request toward the CPU.
module cop0_intr_ctrl #(
    parameter int unsigned REENABLE_HOLD = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [4:0]  hw_irq,
    input  logic        int_ack,
    input  logic [31:0] pc_in,
    output logic        int_req
);

    localparam int unsigned HOLD_W = (REENABLE_HOLD < 2) ? 1 : $clog2(REENABLE_HOLD + 1);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    logic [31:0]       count_q, count_d;
    logic [31:0]       compare_q, compare_d;
    logic [5:0]        im_q, im_d;
    logic              ie_q, ie_d;
    logic [5:0]        ip_q, ip_d;
    logic [31:0]       epc_q, epc_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [4:0]        irq_sync_q, irq_sync_d;
    logic [4:0]        irq_dly_q, irq_dly_d;

    logic       wr_count, wr_compare, wr_status, wr_cause;
    logic       timer_hit;
    logic       int_accept;
    logic [4:0] irq_edge;

    assign wr_count   = we && (waddr == REG_COUNT);
    assign wr_compare = we && (waddr == REG_COMPARE);
    assign wr_status  = we && (waddr == REG_STATUS);
    assign wr_cause   = we && (waddr == REG_CAUSE);

    // Request is held off while the post-reenable window is still counting down.
    assign int_req    = ie_q && ((ip_q & im_q) != 6'd0) && (hold_q == '0);
    assign int_accept = int_ack && int_req;

    // Next-state logic for all CP0 state; sets win over software clears.
    always_comb begin
        count_d    = count_q + 32'd1;
        compare_d  = compare_q;
        im_d       = im_q;
        ie_d       = ie_q;
        ip_d       = ip_q;
        epc_d      = epc_q;
        hold_d     = hold_q;
        irq_sync_d = hw_irq;
        irq_dly_d  = irq_sync_q;
        irq_edge   = irq_sync_q & ~irq_dly_q;

        if (wr_count) begin
            count_d = wdata;
        end
        // Match is against the value Count takes at this edge and the old Compare.
        timer_hit = (count_d == compare_q);

        if (wr_compare) begin
            compare_d = wdata;
        end

        if (wr_cause) begin
            ip_d[4:0] = wdata[14:10];
        end
        ip_d[4:0] = ip_d[4:0] | irq_edge;

        if (wr_compare) begin
            ip_d[5] = 1'b0;
        end else if (timer_hit) begin
            ip_d[5] = 1'b1;
        end

        if (wr_status) begin
            im_d = wdata[15:10];
            ie_d = wdata[0];
        end
        if (int_accept) begin
            ie_d  = 1'b0;
            epc_d = pc_in;
        end

        if (wr_status && ie_d) begin
            hold_d = HOLD_W'(REENABLE_HOLD);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q    <= '0;
            compare_q  <= '0;
            im_q       <= '0;
            ie_q       <= 1'b0;
            ip_q       <= '0;
            epc_q      <= '0;
            hold_q     <= '0;
            irq_sync_q <= '0;
            irq_dly_q  <= '0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            im_q       <= im_d;
            ie_q       <= ie_d;
            ip_q       <= ip_d;
            epc_q      <= epc_d;
            hold_q     <= hold_d;
            irq_sync_q <= irq_sync_d;
            irq_dly_q  <= irq_dly_d;
        end
    end

    // mfc0 read mux.
    always_comb begin
        rdata = '0;
        case (raddr)
            REG_COUNT:   rdata = count_q;
            REG_COMPARE: rdata = compare_q;
            REG_STATUS:  rdata = {16'd0, im_q, 9'd0, ie_q};
            REG_CAUSE:   rdata = {16'd0, ip_q, 10'd0};
            REG_EPC:     rdata = epc_q;
            default:     rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cop0_intr_ctrl.sv
// Bench for cop0_intr_ctrl: directed plan steps plus a randomized phase,
// all checked against a behavioural register-level model.
module tb_cop0_intr_ctrl;

    localparam int unsigned HOLD = 3;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [4:0]  hw_irq;
    logic        int_ack;
    logic [31:0] pc_in;
    logic        int_req;

    int checks   = 0;
    int failures = 0;

    cop0_intr_ctrl #(.REENABLE_HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr),
        .rdata   (rdata),
        .hw_irq  (hw_irq),
        .int_ack (int_ack),
        .pc_in   (pc_in),
        .int_req (int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural registers as plain 32-bit words.
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    int          cyc        = 0;
    int          hold_until = 0;
    logic [4:0]  hw_hist[$];

    function automatic logic model_req();
        return m_status[0] && ((m_cause[15:10] & m_status[15:10]) != 6'd0) && (cyc >= hold_until);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        logic        req;
        logic [31:0] nxt_count;
        logic [31:0] nxt_cause;
        logic [4:0]  edges;
        req = model_req();
        cyc++;
        if (!rst) begin
            m_count = 0; m_compare = 0; m_status = 0; m_cause = 0; m_epc = 0;
            hold_until = 0;
            hw_hist = {5'd0, 5'd0};
            return;
        end
        edges = hw_hist[1] & ~hw_hist[0];
        hw_hist.push_back(hw_irq);
        void'(hw_hist.pop_front());

        nxt_count = (we && waddr == 5'd9) ? wdata : m_count + 32'd1;
        nxt_cause = m_cause;
        if (we && waddr == 5'd13) nxt_cause[14:10] = wdata[14:10];
        nxt_cause[14:10] = nxt_cause[14:10] | edges;
        if (we && waddr == 5'd11)          nxt_cause[15] = 1'b0;
        else if (nxt_count == m_compare)   nxt_cause[15] = 1'b1;

        if (we && waddr == 5'd12) m_status = wdata & 32'h0000_FC01;
        if (int_ack && req) begin
            m_status[0] = 1'b0;
            m_epc = pc_in;
        end
        if (we && waddr == 5'd12 && m_status[0]) hold_until = cyc + HOLD;
        if (we && waddr == 5'd11) m_compare = wdata;
        m_count = nxt_count;
        m_cause = nxt_cause;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        raddr = a;
        #1;
        v = rdata;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] v;
        logic [4:0]  other;
        rd(5'd9, v);  chk({tag, "_count"}, v, model_read(5'd9));
        rd(5'd11, v); chk({tag, "_compare"}, v, model_read(5'd11));
        rd(5'd12, v); chk({tag, "_status"}, v, model_read(5'd12));
        rd(5'd13, v); chk({tag, "_cause"}, v, model_read(5'd13));
        rd(5'd14, v); chk({tag, "_epc"}, v, model_read(5'd14));
        other = 5'($urandom);
        rd(other, v); chk({tag, "_other"}, v, model_read(other));
        chk({tag, "_int_req"}, 32'(int_req), 32'(model_req()));
    endtask

    initial begin
        logic [31:0] v;
        hw_hist = {5'd0, 5'd0};
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        hw_irq = '0; int_ack = 1'b0; pc_in = '0;

        // Reset
        tick(); tick();
        check_all("reset");
        for (int a = 9; a <= 14; a++) begin
            rd(5'(a), v); chk("reset_zero", v, 32'd0);
        end
        chk("reset_int_req", 32'(int_req), 32'd0);
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            rd(5'd9, v); chk("count_run", v, 32'(i));
        end

        // Timer
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd100);
        for (int i = 0; i < 200; i++) begin
            tick();
            rd(5'd9, v); chk("timer_count", v, model_read(5'd9));
            if (int_req === 1'b1) break;
        end
        rd(5'd9, v);  chk("timer_hit_count", v, 32'd100);
        rd(5'd13, v); chk("timer_ip7", v, 32'h0000_8000);
        chk("timer_int_req", 32'(int_req), 32'd1);
        int_ack = 1'b1; pc_in = 32'h40;
        tick();
        int_ack = 1'b0;
        rd(5'd14, v); chk("ack_epc", v, 32'h40);
        rd(5'd12, v); chk("ack_status", v, 32'h0000_8000);
        chk("ack_int_req", 32'(int_req), 32'd0);
        mtc0(5'd11, 32'd50_000_100);
        rd(5'd13, v); chk("compare_clr_ip7", v, 32'd0);
        check_all("timer_end");

        // UART request
        mtc0(5'd12, 32'h0000_0401);
        hw_irq = 5'b00001;
        for (int i = 0; i < 5; i++) begin
            tick();
            rd(5'd13, v); chk("uart_cause", v, model_read(5'd13));
        end
        hw_irq = 5'b00000;
        tick(); tick(); tick();
        rd(5'd13, v); chk("uart_sticky", v, 32'h0000_0400);
        chk("uart_int_req", 32'(int_req), 32'd1);
        mtc0(5'd13, 32'd0);
        rd(5'd13, v); chk("uart_clear", v, 32'd0);
        chk("uart_clear_req", 32'(int_req), 32'd0);

        // Masking
        mtc0(5'd12, 32'h0000_0001);
        hw_irq = 5'b10000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mask_req_low", 32'(int_req), 32'd0);
        end
        rd(5'd13, v); chk("mask_cause", v, 32'h0000_4000);
        mtc0(5'd12, 32'h0000_4001);
        chk("hold_n", 32'(int_req), 32'd0);
        tick(); chk("hold_n1", 32'(int_req), 32'd0);
        tick(); chk("hold_n2", 32'(int_req), 32'd0);
        tick(); chk("hold_n3", 32'(int_req), 32'd1);
        check_all("mask_end");

        // Collision: Cause write vs hw edge
        hw_irq = 5'b00000;
        tick(); tick();
        mtc0(5'd13, 32'd0);
        rd(5'd13, v); chk("coll_pre_clear", v, 32'd0);
        hw_irq = 5'b10000;
        tick();
        mtc0(5'd13, 32'd0);
        rd(5'd13, v); chk("coll_edge_wins", v, 32'h0000_4000);

        // Collision: Compare write vs timer match
        mtc0(5'd11, 32'd1000);
        mtc0(5'd9, 32'd995);
        tick(); tick(); tick(); tick();
        rd(5'd9, v); chk("coll_count_999", v, 32'd999);
        mtc0(5'd11, 32'd77);
        rd(5'd9, v);  chk("coll_count_1000", v, 32'd1000);
        rd(5'd13, v); chk("coll_ip7_clear", v & 32'h0000_8000, 32'd0);
        check_all("coll_end");

        // Spurious ack
        mtc0(5'd12, 32'h0000_0001);
        chk("spur_req_low", 32'(int_req), 32'd0);
        int_ack = 1'b1; pc_in = 32'h1234;
        tick();
        int_ack = 1'b0;
        rd(5'd14, v); chk("spur_epc", v, 32'h40);
        rd(5'd12, v); chk("spur_status", v, 32'h0000_0001);

        // Wrap
        mtc0(5'd11, 32'd0);
        mtc0(5'd9, 32'hFFFF_FFFF);
        rd(5'd9, v); chk("wrap_max", v, 32'hFFFF_FFFF);
        tick();
        rd(5'd9, v);  chk("wrap_zero", v, 32'd0);
        rd(5'd13, v); chk("wrap_ip7", v & 32'h0000_8000, 32'h0000_8000);
        check_all("wrap_end");

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            we  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       waddr = 5'd9;
                1:       waddr = 5'd11;
                2:       waddr = 5'd12;
                3:       waddr = 5'd13;
                4:       waddr = 5'd14;
                default: waddr = 5'($urandom);
            endcase
            wdata = $urandom;
            if (waddr == 5'd11 && $urandom_range(0, 1) == 1)
                wdata = m_count + 32'($urandom_range(1, 6));
            if (waddr == 5'd9 && $urandom_range(0, 1) == 1)
                wdata = m_compare - 32'($urandom_range(1, 4));
            if (waddr == 5'd12 && $urandom_range(0, 1) == 1)
                wdata = wdata | 32'h1;
            if ($urandom_range(0, 5) == 0) hw_irq = 5'($urandom);
            int_ack = ($urandom_range(0, 3) == 0);
            pc_in   = $urandom;
            tick();
            we = 1'b0; int_ack = 1'b0; rst = 1'b1;
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
